// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: widths, reset PC, fetch queue entry
// layout and the fetch FSM state encoding.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC = 32'h7600_0000;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

    // A fetch target is usable only when it is word aligned.
    function automatic logic is_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO of fetch entries. Slot 0 is always the head, so
// the head leaves straight from a register with no output mux. Flush empties
// the queue and takes priority over push/pop.
module fetch_queue
    import riscv_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t din_i,
    output fetch_entry_t head_o,
    output logic [1:0]   count_o,
    output logic         valid_o
);

    fetch_entry_t r_slot0;
    fetch_entry_t r_slot1;
    logic [1:0]   r_count;

    fetch_entry_t w_slot0_nxt;
    fetch_entry_t w_slot1_nxt;
    logic [1:0]   w_count_nxt;

    // Next-state of the shift-style queue; pop only matters when non-empty,
    // and the caller never pushes into a full queue without a pop.
    always_comb begin
        w_slot0_nxt = r_slot0;
        w_slot1_nxt = r_slot1;
        w_count_nxt = r_count;
        if (flush_i) begin
            w_count_nxt = 2'd0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (push_i) begin
                        w_slot0_nxt = din_i;
                        w_count_nxt = 2'd1;
                    end
                end
                2'd1: begin
                    if (push_i && pop_i) begin
                        w_slot0_nxt = din_i;
                    end else if (push_i) begin
                        w_slot1_nxt = din_i;
                        w_count_nxt = 2'd2;
                    end else if (pop_i) begin
                        w_count_nxt = 2'd0;
                    end
                end
                2'd2: begin
                    if (pop_i) begin
                        w_slot0_nxt = r_slot1;
                        if (push_i) begin
                            w_slot1_nxt = din_i;
                        end else begin
                            w_count_nxt = 2'd1;
                        end
                    end
                end
                default: begin
                    w_count_nxt = 2'd0;
                end
            endcase
        end
    end

    // Head slot and occupancy; head is cleared on reset so decode sees zeros.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= 2'd0;
            r_slot0 <= '0;
        end else begin
            r_count <= w_count_nxt;
            r_slot0 <= w_slot0_nxt;
        end
    end

    // Second slot is pure data and needs no reset.
    always_ff @(posedge clk_i) begin
        r_slot1 <= w_slot1_nxt;
    end

    assign head_o  = r_slot0;
    assign count_o = r_count;
    assign valid_o = (r_count != 2'd0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the combinational instruction
// memory at the PC and queues {pc, instr} for decode. Redirects from execute
// flush the queue and reload the PC; a misaligned target halts fetch until an
// aligned redirect or reset.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] im_addr_o,
    input  logic [31:0] im_rd_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        misalign_o
);

    logic [XLEN-1:0] r_pc;
    fetch_state_t    r_state;
    logic            r_misalign;

    logic [XLEN-1:0] w_pc_nxt;
    fetch_state_t    w_state_nxt;
    logic            w_misalign_nxt;
    logic            w_push;
    logic            w_pop;
    logic            w_valid;
    logic [1:0]      w_count;
    fetch_entry_t    w_din;
    fetch_entry_t    w_head;

    assign w_pop = w_valid && instr_ready_i;
    assign w_din = '{pc: r_pc, instr: im_rd_i};

    // Next PC / FSM: redirect wins over push; push only while running and the
    // queue has room (or is draining a slot this cycle).
    always_comb begin
        w_pc_nxt       = r_pc;
        w_state_nxt    = r_state;
        w_misalign_nxt = r_misalign;
        w_push         = 1'b0;
        if (redirect_i) begin
            if (is_aligned(redirect_pc_i)) begin
                w_pc_nxt       = redirect_pc_i;
                w_state_nxt    = ST_RUN;
                w_misalign_nxt = 1'b0;
            end else begin
                w_pc_nxt       = redirect_pc_i & ~32'd3;
                w_state_nxt    = ST_HALT;
                w_misalign_nxt = 1'b1;
            end
        end else if (r_state == ST_RUN) begin
            if ((w_count != 2'd2) || w_pop) begin
                w_push   = 1'b1;
                w_pc_nxt = r_pc + PC_STEP;
            end
        end
    end

    // PC, FSM state and sticky misalign flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc       <= RESET_PC;
            r_state    <= ST_RUN;
            r_misalign <= 1'b0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_state    <= w_state_nxt;
            r_misalign <= w_misalign_nxt;
        end
    end

    fetch_queue u_queue (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .flush_i (redirect_i),
        .din_i   (w_din),
        .head_o  (w_head),
        .count_o (w_count),
        .valid_o (w_valid)
    );

    assign im_addr_o     = r_pc;
    assign instr_valid_o = w_valid;
    assign instr_o       = w_head.instr;
    assign pc_o          = w_head.pc;
    assign misalign_o    = r_misalign;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage: owns the program counter, drives the instruction memory `im` read address, and delivers fetched instruction words with their PC to decode over a valid/ready handshake. `im` is a combinational read (address in, word out in the same cycle). `fetch_unit` registers each fetched word into a 2-entry queue, which decouples decode stalls from the PC. Branch/jump redirects from execute flush the queue and reload the PC.

## Interface
- `RESET_PC`, 32'h76000000: PC loaded on reset; base of instruction memory.
- `clk_i`  in  1  single clock; all state updates on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `im_addr_o`  out  32  read address to `im`; equals current PC register.
- `im_rd_i`  in  32  instruction word from `im` for `im_addr_o`, same cycle.
- `redirect_i`  in  1  execute requests PC change this cycle.
- `redirect_pc_i`  in  32  target PC when `redirect_i`=1.
- `instr_valid_o`  out  1  queue head holds a valid instruction.
- `instr_ready_i`  in  1  decode accepts the head this cycle.
- `instr_o`  out  32  instruction word at queue head.
- `pc_o`  out  32  PC of `instr_o`.
- `misalign_o`  out  1  sticky: last redirect target had `[1:0]`≠0; fetch halted.

## Operation
- State: `pc_q`[31:0], 2-entry queue {pc, instr}, count [1:0], FSM {RUN, HALT}.
- Reset (`rst_i`=1 at edge): `pc_q`=RESET_PC, count=0, FSM=RUN, `misalign_o`=0. Outputs after reset: `instr_valid_o`=0, `im_addr_o`=RESET_PC, `instr_o`=0, `pc_o`=0. Reset overrides redirect and handshake in the same cycle.
- Pop occurs when `instr_valid_o`&&`instr_ready_i`.
- Push occurs in RUN when no redirect and (count<2, or count==2 and pop). Push writes {`pc_q`, `im_rd_i`} at the tail and sets `pc_q`←`pc_q`+4. Addition wraps modulo 2^32 (32'hFFFFFFFC+4 = 0).
- Simultaneous push and pop: count unchanged, order preserved.
- Full with no pop: no push; `pc_q` holds. `im_addr_o` stays stable, so the same word is re-read the next cycle.
- Redirect (`redirect_i`=1), priority over push:
  - A pop presented that cycle completes, because decode observed the handshake.
  - All remaining queue entries are discarded; count=0 next cycle.
  - Aligned target (`redirect_pc_i[1:0]`=0): `pc_q`←`redirect_pc_i`, FSM=RUN.
  - Misaligned target: `pc_q`←`redirect_pc_i`&~3, FSM=HALT, `misalign_o`←1.
- HALT: no pushes and no fetch. Any existing entries were already flushed. Exits only via an aligned redirect, which clears `misalign_o` and returns to RUN, or via reset.
- `instr_o`/`pc_o` are driven from the head register. Their value is unspecified when `instr_valid_o`=0, except immediately after reset (0).
- `instr_o`/`pc_o` must remain stable while `instr_valid_o`=1 and `instr_ready_i`=0.

## Timing
- Fetch latency: the address in `pc_q` at edge N produces `instr_valid_o`=1 after edge N+1 (one registered stage).
- First instruction after reset deassert: valid the cycle after the first non-reset edge, with `pc_o`=RESET_PC.
- Throughput: 1 instruction/cycle while `instr_ready_i`=1.
- Redirect: `instr_valid_o`=0 in the cycle after the redirect edge. The target instruction is valid one cycle after that (2-cycle bubble).
- Combinational paths:
  - `im_addr_o` comes from `pc_q` only.
  - `instr_valid_o`, `instr_o` and `pc_o` come from registers only.
  - No combinational path from `instr_ready_i` or `redirect_i` to any output.

## Structure
- Shared package `riscv_pkg`: `XLEN`=32, `ILEN`=32, `RESET_PC` default 32'h76000000, `PC_STEP`=4. Also holds the typedef `fetch_entry_t` {pc, instr}.
- Sub-module `fetch_queue`: 2-entry synchronous FIFO of `fetch_entry_t` with push, pop, flush, count and registered head. `fetch_unit` holds the PC, FSM and push/redirect control.

## Test plan
- Reset then `instr_ready_i`=1 with the `im` model from file: `pc_o` sequence is 76000000, 76000004, 76000008, … on consecutive cycles. `instr_o` matches the file words and `instr_valid_o` stays 1.
- Hold `instr_ready_i`=0 for 5 cycles after first valid: count saturates at 2, `im_addr_o` stays at 76000008, and head stays {76000000, word0}. On release, 76000000 then 76000004 then 76000008 arrive in order with no loss or duplication.
- Redirect to 76000040 while the queue is full and a pop occurs the same cycle: the popped entry is accepted, the queue is flushed, the next valid `pc_o` is 76000040 after the 2-cycle bubble, and no stale PCs appear.
- Redirect to 76000042: `misalign_o`=1, `im_addr_o`=76000040, no `instr_valid_o` for 10 cycles. A later redirect to 76000080 clears `misalign_o` and fetch resumes at 76000080.
- Redirect to FFFFFFFC: `pc_o` sequence is FFFFFFFC then 00000000 (wrap).
- Assert `rst_i` mid-stream with the queue full and `redirect_i`=1: next cycle `instr_valid_o`=0, `im_addr_o`=76000000, `misalign_o`=0.
